addsub_accum_ctrl: RTL and testbench

- Sequencer for the shared 5-bit signed add/subtract datapath: the two's-complement B path, ripple-carry adder and validity checker.
- User operands are entered one at a time. Each operand is added to or subtracted from a running signed accumulator through the datapath.
- Every result is gated on the datapath's validity flag. The controller presents the accumulator, a sticky overflow flag and an operation count to the seven-segment display path.

---
 rtl/addsub_pkg.sv | 28 ++
 rtl/btn_sync_edge.sv | 38 +++
 rtl/addsub_accum_ctrl.sv | 128 ++++++++++++
 tb/tb_addsub_accum_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared types and constants for the add/subtract accumulator
//            controller: sequencer states, default widths and signed limits.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Sequencer states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    COMMIT = 3'd2,
    ERROR  = 3'd3,
    FULL   = 3'd4
  } state_t;

  localparam int W_DEF       = 5;
  localparam int MAX_OPS_DEF = 8;

  // Accumulator zero and signed range limits for the default width
  localparam logic signed [W_DEF-1:0] ACC_ZERO = '0;
  localparam int S_MAX = 15;
  localparam int S_MIN = -16;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Purpose  : Two-flop synchroniser for a raw button plus a rising-edge
//            detector; provides both the synchronised level and a one-cycle
//            pulse per press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync_d;

  // Metastability chain followed by one history flop for edge detection
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign level = sync2;
  assign pulse = sync2 & ~sync_d;

endmodule
`default_nettype wire

// File: rtl/addsub_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addsub_accum_ctrl
// Purpose  : Sequencer for the shared signed add/subtract datapath. Captures
//            one operand per enter press, issues it against the accumulator,
//            and commits the datapath result only when it reports no
//            overflow. Tracks a sticky overflow flag and committed-op count.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_accum_ctrl
  import addsub_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MAX_OPS = MAX_OPS_DEF,
  parameter int CW      = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          btn_enter,
  input  logic          btn_clear,
  input  logic          sub_sel,
  input  logic [W-1:0]  sw_operand,
  output logic [W-1:0]  dp_a,
  output logic [W-1:0]  dp_b,
  output logic          dp_sub,
  input  logic [W-1:0]  dp_sum,
  input  logic          dp_valid,
  output logic [W-1:0]  acc,
  output logic          ovf,
  output logic          full,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] op_count
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);

  state_t        state;
  logic [W-1:0]  operand;
  logic          sub_reg;
  logic          enter_pulse;
  logic          clear_s;
  logic          enter_level_unused;
  logic          clear_edge_unused;
  logic [CW-1:0] next_count;

  btn_sync_edge u_enter_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .btn   (btn_enter),
    .level (enter_level_unused),
    .pulse (enter_pulse)
  );

  // Clear is level-sensed, so only the synchronised level is consumed
  btn_sync_edge u_clear_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .btn   (btn_clear),
    .level (clear_s),
    .pulse (clear_edge_unused)
  );

  assign next_count = op_count + CW'(1);

  // Operand capture, issue/commit sequencing and result bookkeeping
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      acc      <= '0;
      operand  <= '0;
      sub_reg  <= 1'b0;
      op_count <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Clear wins over a coincident enter; that enter is dropped
          if (clear_s) begin
            acc      <= '0;
            op_count <= '0;
            ovf      <= 1'b0;
            state    <= IDLE;
          end else if (enter_pulse) begin
            operand <= sw_operand;
            sub_reg <= sub_sel;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Settle cycle for the combinational datapath
          state <= COMMIT;
        end
        COMMIT: begin
          done <= 1'b1;
          if (dp_valid) begin
            acc      <= dp_sum;
            op_count <= next_count;
            state    <= (next_count == MAX_CNT) ? FULL : IDLE;
          end else begin
            ovf   <= 1'b1;
            state <= ERROR;
          end
        end
        ERROR, FULL: begin
          // Only a clear leaves these terminal states
          if (clear_s) begin
            acc      <= '0;
            op_count <= '0;
            ovf      <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dp_a   = acc;
  assign dp_b   = operand;
  assign dp_sub = sub_reg;
  assign busy   = (state == ISSUE) || (state == COMMIT);
  assign full   = (op_count == MAX_CNT);

endmodule
`default_nettype wire

// File: tb/tb_addsub_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_accum_ctrl
// Purpose  : Scoreboard bench for addsub_accum_ctrl with a behavioural signed
//            add/subtract datapath attached to the dp_* ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_accum_ctrl;
  import addsub_pkg::*;

  localparam int W       = 5;
  localparam int MAX_OPS = 8;
  localparam int CW      = 4;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                btn_enter = 1'b0;
  logic                btn_clear = 1'b0;
  logic                sub_sel = 1'b0;
  logic signed [W-1:0] sw_operand = '0;
  logic signed [W-1:0] dp_a;
  logic signed [W-1:0] dp_b;
  logic                dp_sub;
  logic signed [W-1:0] dp_sum;
  logic                dp_valid;
  logic signed [W-1:0] acc;
  logic                ovf;
  logic                full;
  logic                busy;
  logic                done;
  logic [CW-1:0]       op_count;

  addsub_accum_ctrl #(.W(W), .MAX_OPS(MAX_OPS), .CW(CW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .sub_sel    (sub_sel),
    .sw_operand (sw_operand),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_sub     (dp_sub),
    .dp_sum     (dp_sum),
    .dp_valid   (dp_valid),
    .acc        (acc),
    .ovf        (ovf),
    .full       (full),
    .busy       (busy),
    .done       (done),
    .op_count   (op_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural datapath: exact sum in 7 bits, valid when it fits in W bits
  logic signed [W+1:0] dp_ext;
  assign dp_ext   = dp_sub ? (dp_a - dp_b) : (dp_a + dp_b);
  assign dp_sum   = dp_ext[W-1:0];
  assign dp_valid = (dp_ext >= S_MIN) && (dp_ext <= S_MAX);

  typedef struct {
    logic signed [W-1:0] acc;
    logic [CW-1:0]       cnt;
    logic                ovf;
    int                  cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (RST_N && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_acc", int'(acc), int'(mon_e.acc));
        chk("commit_op_count", int'(op_count), int'(mon_e.cnt));
        chk("commit_ovf", int'(ovf), int'(mon_e.ovf));
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One enter press; expect_done queues the committed result
  task automatic do_op(input logic signed [W-1:0] op, input logic sub,
                       input bit expect_done, input logic signed [W-1:0] prev_acc,
                       input logic signed [W-1:0] e_acc, input int e_cnt,
                       input bit e_ovf);
    int t0;
    @(posedge CLK); #2;
    sw_operand = op;
    sub_sel    = sub;
    btn_enter  = 1'b1;
    t0 = cyc;
    if (expect_done) sb.push_back('{e_acc, CW'(e_cnt), e_ovf, t0 + 5});
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    if (expect_done) begin
      chk("issue_busy", int'(busy), 1);
      chk("issue_dp_a", int'(dp_a), int'(prev_acc));
      chk("issue_dp_b", int'(dp_b), int'(op));
      chk("issue_dp_sub", int'(dp_sub), int'(sub));
    end else begin
      chk("ignored_busy", int'(busy), 0);
    end
    repeat (3) @(posedge CLK);
    #2 btn_enter = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic do_clear();
    @(posedge CLK); #2 btn_clear = 1'b1;
    repeat (4) @(posedge CLK);
    #2 btn_clear = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("clear_acc", int'(acc), int'(ACC_ZERO));
    chk("clear_op_count", int'(op_count), 0);
    chk("clear_ovf", int'(ovf), 0);
    chk("clear_full", int'(full), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_busy;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_acc", int'(acc), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_op_count", int'(op_count), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_full", int'(full), 0);

    // Add, subtract, then build up to 12
    do_op(5'sd5,  1'b0, 1, 5'sd0,  5'sd5,  1, 0);
    do_op(5'sd3,  1'b1, 1, 5'sd5,  5'sd2,  2, 0);
    do_op(5'sd10, 1'b0, 1, 5'sd2,  5'sd12, 3, 0);

    // 12 + 7 overflows: acc holds, ovf set, further enters ignored
    do_op(5'sd7,  1'b0, 1, 5'sd12, 5'sd12, 3, 1);
    do_op(5'sd1,  1'b0, 0, 5'sd12, 5'sd12, 3, 1);
    @(negedge CLK);
    chk("error_acc_hold", int'(acc), 12);
    chk("error_ovf", int'(ovf), 1);
    do_clear();

    // Fill to MAX_OPS with +1 entries
    for (int i = 0; i < MAX_OPS; i++)
      do_op(5'sd1, 1'b0, 1, W'(i), W'(i + 1), i + 1, 0);
    @(negedge CLK);
    chk("full_flag", int'(full), 1);
    chk("full_acc", int'(acc), 8);
    do_op(5'sd1, 1'b0, 0, 5'sd8, 5'sd8, 8, 0);
    @(negedge CLK);
    chk("full_acc_hold", int'(acc), 8);
    chk("full_count_hold", int'(op_count), 8);
    do_clear();

    // 0 - (-16) = +16 is out of range
    do_op(W'(S_MIN), 1'b1, 1, 5'sd0, 5'sd0, 0, 1);
    do_clear();

    // Clear and enter rising together: clear wins, no issue
    do_op(5'sd4, 1'b0, 1, 5'sd0, 5'sd4, 1, 0);
    @(posedge CLK); #2;
    sw_operand = 5'sd3;
    sub_sel    = 1'b0;
    btn_enter  = 1'b1;
    btn_clear  = 1'b1;
    saw_busy   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (busy) saw_busy = 1'b1;
    end
    #1;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("simul_no_issue", int'(saw_busy), 0);
    chk("simul_acc", int'(acc), 0);
    chk("simul_op_count", int'(op_count), 0);

    // Reset asserted during the COMMIT cycle of 6 + 1
    do_op(5'sd6, 1'b0, 1, 5'sd0, 5'sd6, 1, 0);
    @(posedge CLK); #2;
    sw_operand = 5'sd1;
    sub_sel    = 1'b0;
    btn_enter  = 1'b1;
    repeat (2) @(posedge CLK);
    #2 btn_enter = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_commit_acc", int'(acc), 0);
    chk("rst_commit_done", int'(done), 0);
    chk("rst_commit_op_count", int'(op_count), 0);
    chk("rst_commit_busy", int'(busy), 0);
    @(posedge CLK); #2 RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    do_op(5'sd2, 1'b0, 1, 5'sd0, 5'sd2, 1, 0);

    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
